// File: rtl/rgb_timing_pkg.sv
// Shared types and timing defaults for the RGB panel timing generator.
// Totals are computed here so both axes and the top agree on them.
package rgb_timing_pkg;

  localparam int CNT_W     = 12;
  localparam int MAX_TOTAL = 4096;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    RUN
  } state_e;

  localparam int   DEF_H_ACTIVE = 800;
  localparam int   DEF_H_FP     = 40;
  localparam int   DEF_H_SYNC   = 48;
  localparam int   DEF_H_BP     = 40;
  localparam int   DEF_V_ACTIVE = 480;
  localparam int   DEF_V_FP     = 13;
  localparam int   DEF_V_SYNC   = 3;
  localparam int   DEF_V_BP     = 29;
  localparam logic DEF_SYNC_POL = 1'b0;

  function automatic int axis_total(
    input int sync,
    input int bp,
    input int active,
    input int fp
  );
    return sync + bp + active + fp;
  endfunction

endpackage

// File: rtl/rgb_timing_gen_if.sv
// Control levels in, registered panel timing out.
// master = timing generator, slave = readout stage.
interface rgb_timing_gen_if;
  import rgb_timing_pkg::*;

  logic             Enable;
  logic             Frame_Ready;
  logic             VSA;
  logic             HSA;
  logic             DE;
  logic [CNT_W-1:0] Pixel_X;
  logic [CNT_W-1:0] Pixel_Y;
  logic             Frame_Start;
  logic             Line_Start;
  logic             Busy;

  modport master (
    input  Enable, Frame_Ready,
    output VSA, HSA, DE, Pixel_X, Pixel_Y,
    output Frame_Start, Line_Start, Busy
  );

  modport slave (
    output Enable, Frame_Ready,
    input  VSA, HSA, DE, Pixel_X, Pixel_Y,
    input  Frame_Start, Line_Start, Busy
  );

endinterface

// File: rtl/sync_axis_counter.sv
// One timing axis: sync, back porch, active, front porch.
// Segment flags and the active index decode straight off the count.
module sync_axis_counter
  import rgb_timing_pkg::*;
#(
  parameter int SYNC   = 1,
  parameter int BP     = 1,
  parameter int ACTIVE = 1,
  parameter int FP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             in_sync_o,
  output logic             in_active_o,
  output logic [CNT_W-1:0] active_index_o
);

  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
  localparam int A0    = SYNC + BP;
  localparam int A1    = A0 + ACTIVE;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign count_o        = cnt_q;
  assign wrap_o         = advance_i
                       && (cnt_q == CNT_W'(TOTAL - 1));
  assign in_sync_o      = cnt_q < CNT_W'(SYNC);
  assign in_active_o    = (cnt_q >= CNT_W'(A0))
                       && (cnt_q < CNT_W'(A1));
  assign active_index_o = cnt_q - CNT_W'(A0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)        cnt_d = '0;
    else if (wrap_o)    cnt_d = '0;
    else if (advance_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_timing_gen.sv
// RGB panel timing generator: waits for a buffered frame, then scans
// whole frames; all panel outputs are registered counter decodes.
module rgb_timing_gen
  import rgb_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic             Sys_Clock,
  input  logic             Reset,
  rgb_timing_gen_if.master tim
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("rgb_timing_gen: axis total exceeds 12-bit counter range");
  end

  state_e           state_q;
  logic             run;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_idx, v_idx;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync, h_act, v_act;

  logic             vsa_q, hsa_q, de_q;
  logic [CNT_W-1:0] x_q, y_q;
  logic             fs_q, ls_q, busy_q;

  assign run = (state_q == RUN);

  sync_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)
  ) u_h (
    .clk            (Sys_Clock),
    .rst_n          (Reset),
    .clear_i        (!run),
    .advance_i      (run),
    .count_o        (h_cnt),
    .wrap_o         (h_wrap),
    .in_sync_o      (h_sync),
    .in_active_o    (h_act),
    .active_index_o (h_idx)
  );

  sync_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)
  ) u_v (
    .clk            (Sys_Clock),
    .rst_n          (Reset),
    .clear_i        (!run),
    .advance_i      (h_wrap),
    .count_o        (v_cnt),
    .wrap_o         (v_wrap),
    .in_sync_o      (v_sync),
    .in_active_o    (v_act),
    .active_index_o (v_idx)
  );

  // v_wrap marks the last clock of a frame; only there may RUN end.
  always_ff @(posedge Sys_Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      vsa_q   <= ~SYNC_POL;
      hsa_q   <= ~SYNC_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tim.Enable) state_q <= WAIT_READY;
        end
        WAIT_READY: begin
          if (!tim.Enable)          state_q <= IDLE;
          else if (tim.Frame_Ready) state_q <= RUN;
        end
        RUN: begin
          if (v_wrap && !tim.Enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      vsa_q  <= run ? (v_sync ~^ SYNC_POL) : ~SYNC_POL;
      hsa_q  <= run ? (h_sync ~^ SYNC_POL) : ~SYNC_POL;
      de_q   <= run && h_act && v_act;
      x_q    <= (run && h_act && v_act) ? h_idx : '0;
      y_q    <= (run && h_act && v_act) ? v_idx : '0;
      fs_q   <= run && (h_cnt == '0) && (v_cnt == '0);
      ls_q   <= run && (h_cnt == '0);
      busy_q <= run;
    end
  end

  assign tim.VSA         = vsa_q;
  assign tim.HSA         = hsa_q;
  assign tim.DE          = de_q;
  assign tim.Pixel_X     = x_q;
  assign tim.Pixel_Y     = y_q;
  assign tim.Frame_Start = fs_q;
  assign tim.Line_Start  = ls_q;
  assign tim.Busy        = busy_q;

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Bench for rgb_timing_gen on small timing sets (active-low and
// active-high sync); pixels are checked through a scoreboard queue.
module tb_rgb_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int qx[$];
  int qy[$];

  rgb_timing_gen_if a_if ();
  rgb_timing_gen_if b_if ();

  // A: H 1/2/4/1 (8), V 1/1/3/1 (6), active-low sync
  rgb_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut_a (
    .Sys_Clock (clk),
    .Reset     (rst_n),
    .tim       (a_if)
  );

  // B: H 2/2/5/1 (10), V 2/1/2/1 (6), active-high sync
  rgb_timing_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_b (
    .Sys_Clock (clk),
    .Reset     (rst_n),
    .tim       (b_if)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end
  endtask

  task automatic wait_fs(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? b_if.Frame_Start : a_if.Frame_Start) && n < 20);
  endtask

  // Scoreboard monitor: every DE clock of A consumes one expected pixel.
  always @(negedge clk) begin
    if (rst_n && a_if.DE) begin
      if (qx.size() == 0) begin
        chk("de_unexpected", 1, 0);
      end else begin
        chk("pix_x", int'(a_if.Pixel_X), qx.pop_front());
        chk("pix_y", int'(a_if.Pixel_Y), qy.pop_front());
      end
    end
  end

  initial begin
    int n, err, f, tf, h, v;
    int found;
    int de_c[3], fs_c[3], ls_c[3], hl_c[3], vl_c[3];
    int hsa_err, vsa_err, de_err, busy_err;
    int b_fs, b_fs_pos, b_hh, b_vh, b_de, b_err, b_pix;

    a_if.Enable = 0; a_if.Frame_Ready = 0;
    b_if.Enable = 0; b_if.Frame_Ready = 0;

    repeat (3) @(negedge clk);
    chk("rst_a_vsa", int'(a_if.VSA), 1);
    chk("rst_a_hsa", int'(a_if.HSA), 1);
    chk("rst_a_de", int'(a_if.DE), 0);
    chk("rst_a_px", int'(a_if.Pixel_X), 0);
    chk("rst_a_py", int'(a_if.Pixel_Y), 0);
    chk("rst_a_fs", int'(a_if.Frame_Start), 0);
    chk("rst_a_ls", int'(a_if.Line_Start), 0);
    chk("rst_a_busy", int'(a_if.Busy), 0);
    chk("rst_b_vsa", int'(b_if.VSA), 0);
    chk("rst_b_hsa", int'(b_if.HSA), 0);

    // Enabled but no buffered frame: must stay idle.
    rst_n = 1;
    a_if.Enable = 1;
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_if.Busy || a_if.DE || !a_if.HSA || !a_if.VSA) err++;
    end
    chk("wait_ready_idle", err, 0);

    push_frame();
    push_frame();
    a_if.Frame_Ready = 1;
    wait_fs(1'b0, n);
    chk("fs_latency", n, 2);

    for (int i = 0; i < 3; i++) begin
      de_c[i] = 0; fs_c[i] = 0; ls_c[i] = 0;
      hl_c[i] = 0; vl_c[i] = 0;
    end
    hsa_err = 0; vsa_err = 0; de_err = 0; busy_err = 0;

    // t counts samples from the first Frame_Start; frame = 48 clocks.
    for (int t = 0; t < 144; t++) begin
      if (t > 0) @(negedge clk);
      f  = t / 48;
      tf = t % 48;
      h  = t % 8;
      v  = tf / 8;
      de_c[f] += int'(a_if.DE);
      fs_c[f] += int'(a_if.Frame_Start);
      ls_c[f] += int'(a_if.Line_Start);
      hl_c[f] += int'(!a_if.HSA);
      vl_c[f] += int'(!a_if.VSA);
      if (!a_if.HSA != (t < 96 && h == 0)) hsa_err++;
      if (!a_if.VSA != (t < 96 && v == 0)) vsa_err++;
      if (a_if.DE != (t < 96 && h >= 3 && h <= 6
                      && v >= 2 && v <= 4)) de_err++;
      if (a_if.Busy != (t < 96)) busy_err++;
      if (t == 64) a_if.Enable = 0;
    end
    a_if.Frame_Ready = 0;

    chk("f0_de_count", de_c[0], 12);
    chk("f1_de_count", de_c[1], 12);
    chk("idle_de_count", de_c[2], 0);
    chk("f0_fs_count", fs_c[0], 1);
    chk("f1_fs_count", fs_c[1], 1);
    chk("idle_fs_count", fs_c[2], 0);
    chk("f0_ls_count", ls_c[0], 6);
    chk("f0_hsa_low", hl_c[0], 6);
    chk("f0_vsa_low", vl_c[0], 8);
    chk("hsa_pattern", hsa_err, 0);
    chk("vsa_pattern", vsa_err, 0);
    chk("de_pattern", de_err, 0);
    chk("busy_pattern", busy_err, 0);
    chk("sb_empty_1", qx.size(), 0);

    // Reset in the middle of a frame.
    push_frame();
    a_if.Enable = 1;
    a_if.Frame_Ready = 1;
    wait_fs(1'b0, n);
    chk("restart_fs_latency", n, 3);
    found = 0;
    for (int i = 0; i < 48 && found == 0; i++) begin
      if (a_if.DE && a_if.Pixel_X == 2 && a_if.Pixel_Y == 1) found = 1;
      else @(negedge clk);
    end
    chk("found_px_2_1", found, 1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_de", int'(a_if.DE), 0);
    chk("async_rst_hsa", int'(a_if.HSA), 1);
    chk("async_rst_vsa", int'(a_if.VSA), 1);
    chk("async_rst_busy", int'(a_if.Busy), 0);
    chk("async_rst_px", int'(a_if.Pixel_X), 0);
    qx.delete();
    qy.delete();
    @(negedge clk);
    push_frame();
    rst_n = 1;
    wait_fs(1'b0, n);
    chk("post_rst_fs_latency", n, 3);
    a_if.Enable = 0;
    repeat (60) @(negedge clk);
    chk("post_rst_busy", int'(a_if.Busy), 0);
    chk("sb_empty_2", qx.size(), 0);
    a_if.Frame_Ready = 0;

    // Active-high sync instance, 60-clock frames.
    b_if.Enable = 1;
    b_if.Frame_Ready = 1;
    wait_fs(1'b1, n);
    chk("b_fs_latency", n, 3);
    b_fs = 0; b_fs_pos = 0; b_hh = 0; b_vh = 0;
    b_de = 0; b_err = 0; b_pix = 0;
    for (int t = 0; t < 120; t++) begin
      if (t > 0) @(negedge clk);
      tf = t % 60;
      h  = t % 10;
      v  = tf / 10;
      b_fs += int'(b_if.Frame_Start);
      if (b_if.Frame_Start && tf == 0) b_fs_pos++;
      if (t < 60) begin
        b_hh += int'(b_if.HSA);
        b_vh += int'(b_if.VSA);
        b_de += int'(b_if.DE);
      end
      if (b_if.HSA != (h < 2)) b_err++;
      if (b_if.VSA != (v < 2)) b_err++;
      if (b_if.DE != (h >= 4 && h <= 8 && v >= 3 && v <= 4)) b_err++;
      if (b_if.DE && (int'(b_if.Pixel_X) != h - 4
                      || int'(b_if.Pixel_Y) != v - 3)) b_pix++;
    end
    b_if.Enable = 0;
    chk("b_fs_count", b_fs, 2);
    chk("b_fs_period", b_fs_pos, 2);
    chk("b_hsa_high", b_hh, 12);
    chk("b_vsa_high", b_vh, 20);
    chk("b_de_count", b_de, 10);
    chk("b_pattern", b_err, 0);
    chk("b_pixels", b_pix, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
